core_readout_sequencer: RTL and testbench

- Reads hits out of one core column of pixel regions after a trigger.
- Accepts a trigger-ID request, drives the column's token chain and Read strobe, and samples the wired-OR 16-bit region data bus.
- Frames the hits as header, data words and trailer into an internal FIFO that feeds the downstream stream interface.
- Sits between the trigger/readout arbiter and the pixel-region chain.

---
 rtl/core_readout_sequencer.sv | 176 +++++++++++++++++
 tb/tb_core_readout_sequencer.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/core_readout_sequencer.sv
// Reads one core column of pixel regions after a trigger: walks the token chain,
// strobes Read per hit, and frames header / data / trailer words into an output FIFO.
module core_readout_sequencer #(
    parameter int DATA_W     = 16,
    parameter int TRIG_W     = 5,
    parameter int TOK_SETTLE = 2,
    parameter int MAX_HITS   = 64,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                Clk,
    input  logic                Reset,
    input  logic                ReqValid,
    input  logic [TRIG_W-1:0]   ReqTrigId,
    output logic                ReqReady,
    output logic [TRIG_W-1:0]   TrigIdReq,
    output logic                TokToRegions,
    input  logic                TokFromRegions,
    output logic                Read,
    input  logic [DATA_W-1:0]   DataFromRegions,
    output logic                OutValid,
    output logic [DATA_W+1:0]   OutData,
    input  logic                OutReady
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int SW = $clog2(TOK_SETTLE + 1);
    localparam int OW = DATA_W + 2;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
    localparam logic [7:0]    MAX_CNT = 8'(MAX_HITS);
    localparam logic [1:0]    T_HDR   = 2'b01;
    localparam logic [1:0]    T_DAT   = 2'b10;
    localparam logic [1:0]    T_TRL   = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE, S_HDR, S_SETTLE, S_CHECK, S_CAPT, S_TRL
    } state_t;

    state_t            state, state_n;
    logic [TRIG_W-1:0] trig_q;
    logic              tok_q;
    logic              trunc_q;
    logic [7:0]        hit_cnt;
    logic [SW-1:0]     settle_cnt;

    logic              latch_req, tok_set, tok_clr, settle_load, hit_inc, trunc_set;
    logic              push, pop, full, empty;
    logic [OW-1:0]     push_word;

    logic [FIFO_DEPTH-1:0][OW-1:0] mem;
    logic [AW-1:0]     wr_ptr, rd_ptr;
    logic [CW-1:0]     count;
    logic [CW-1:0]     free;

    assign TrigIdReq    = trig_q;
    assign TokToRegions = tok_q;

    // ---------------- sequencer ----------------
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state      <= S_IDLE;
            trig_q     <= '0;
            tok_q      <= 1'b0;
            trunc_q    <= 1'b0;
            hit_cnt    <= '0;
            settle_cnt <= '0;
        end else begin
            state <= state_n;
            if (latch_req) begin
                trig_q  <= ReqTrigId;
                hit_cnt <= '0;
                trunc_q <= 1'b0;
            end
            if (tok_set)      tok_q <= 1'b1;
            else if (tok_clr) tok_q <= 1'b0;
            if (settle_load)             settle_cnt <= SW'(TOK_SETTLE);
            else if (state == S_SETTLE)  settle_cnt <= settle_cnt - SW'(1);
            if (hit_inc && hit_cnt != MAX_CNT) hit_cnt <= hit_cnt + 8'd1;
            if (trunc_set) trunc_q <= 1'b1;
        end
    end

    always_comb begin
        state_n     = state;
        ReqReady    = 1'b0;
        Read        = 1'b0;
        push        = 1'b0;
        push_word   = '0;
        latch_req   = 1'b0;
        tok_set     = 1'b0;
        tok_clr     = 1'b0;
        settle_load = 1'b0;
        hit_inc     = 1'b0;
        trunc_set   = 1'b0;
        unique case (state)
            S_IDLE: begin
                ReqReady = 1'b1;
                if (ReqValid) begin
                    latch_req = 1'b1;
                    state_n   = S_HDR;
                end
            end
            S_HDR: begin
                if (!full) begin
                    push        = 1'b1;
                    push_word   = {T_HDR, {(DATA_W-TRIG_W){1'b0}}, trig_q};
                    tok_set     = 1'b1;
                    settle_load = 1'b1;
                    state_n     = S_SETTLE;
                end
            end
            S_SETTLE: begin
                if (settle_cnt <= SW'(1)) state_n = S_CHECK;
            end
            S_CHECK: begin
                // One FIFO slot is always held back so the trailer can never be blocked.
                if (TokFromRegions) begin
                    state_n = S_TRL;
                end else if (hit_cnt == MAX_CNT) begin
                    trunc_set = 1'b1;
                    state_n   = S_TRL;
                end else if (free >= CW'(2)) begin
                    Read    = 1'b1;
                    state_n = S_CAPT;
                end
            end
            S_CAPT: begin
                push        = 1'b1;
                push_word   = {T_DAT, DataFromRegions};
                hit_inc     = 1'b1;
                settle_load = 1'b1;
                state_n     = S_SETTLE;
            end
            S_TRL: begin
                if (!full) begin
                    push      = 1'b1;
                    push_word = {T_TRL, trunc_q, {(DATA_W-9){1'b0}}, hit_cnt};
                    tok_clr   = 1'b1;
                    state_n   = S_IDLE;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    // ---------------- output FIFO ----------------
    assign full     = (count == DEPTH_C);
    assign empty    = (count == '0);
    assign free     = DEPTH_C - count;
    assign pop      = !empty && OutReady;
    assign OutValid = !empty;
    assign OutData  = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            unique case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage is not reset; stale entries are masked by the pointers and OutValid.
    always_ff @(posedge Clk) begin
        if (push) mem[wr_ptr] <= push_word;
    end

    a_no_push_full: assert property (@(posedge Clk) disable iff (!Reset) !(push && full && !pop));

endmodule

// File: tb/tb_core_readout_sequencer.sv
// Randomized scoreboard bench for core_readout_sequencer with a behavioural region-chain model.
module tb_core_readout_sequencer;
    localparam int DATA_W     = 16;
    localparam int TRIG_W     = 5;
    localparam int TOK_SETTLE = 2;
    localparam int MAX_HITS   = 5;
    localparam int FIFO_DEPTH = 4;
    localparam int OW         = DATA_W + 2;

    logic              Clk = 1'b0;
    logic              Reset = 1'b1;
    logic              ReqValid = 1'b0;
    logic [TRIG_W-1:0] ReqTrigId = '0;
    logic              ReqReady;
    logic [TRIG_W-1:0] TrigIdReq;
    logic              TokToRegions;
    logic              TokFromRegions = 1'b1;
    logic              Read;
    logic [DATA_W-1:0] DataFromRegions = '0;
    logic              OutValid;
    logic [OW-1:0]     OutData;
    logic              OutReady = 1'b0;

    always #5 Clk = ~Clk;

    core_readout_sequencer #(
        .DATA_W(DATA_W), .TRIG_W(TRIG_W), .TOK_SETTLE(TOK_SETTLE),
        .MAX_HITS(MAX_HITS), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .Clk(Clk), .Reset(Reset),
        .ReqValid(ReqValid), .ReqTrigId(ReqTrigId), .ReqReady(ReqReady),
        .TrigIdReq(TrigIdReq), .TokToRegions(TokToRegions), .TokFromRegions(TokFromRegions),
        .Read(Read), .DataFromRegions(DataFromRegions),
        .OutValid(OutValid), .OutData(OutData), .OutReady(OutReady)
    );

    int total = 0;
    int bad   = 0;

    logic [OW-1:0]     exp_q[$];
    logic [DATA_W-1:0] next_hits[$];
    logic [DATA_W-1:0] region_q[$];

    int ready_mode = 2;        // 0 random, 1 held low, 2 held high
    int to_req = 0, to_done = 0;
    int probe_req = 0, probe_done = 0, probe_kind = 0, probe_exp = 0;
    int ev_reads = 0;
    int since_rd = 1000;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, want, $time);
        end
    endtask

    // Downstream ready pattern
    always @(posedge Clk) begin
        #1;
        case (ready_mode)
            0:       OutReady = ($urandom_range(0, 3) != 0);
            1:       OutReady = 1'b0;
            default: OutReady = 1'b1;
        endcase
    end

    // Region chain: holds the event's hits; token high once nothing is left; data the cycle after Read.
    always begin : region_model
        logic acc, rd;
        @(negedge Clk);
        acc = ReqValid && ReqReady;
        rd  = Read;
        @(posedge Clk);
        #1;
        DataFromRegions = '0;
        if (!Reset) begin
            region_q.delete();
        end else begin
            if (acc) region_q = next_hits;
            if (rd && region_q.size() > 0) DataFromRegions = region_q.pop_front();
        end
        TokFromRegions = (region_q.size() == 0);
    end

    // Monitor: scoreboard pops, stall stability, Read protocol, reset values
    logic [OW-1:0]     held = '0;
    logic              stalled = 1'b0;
    logic [TRIG_W-1:0] cur_id = '0;

    always @(negedge Clk) begin
        if (!Reset) begin
            check("reset_outs", {ReqReady, OutValid, Read, TokToRegions, TrigIdReq, OutData},
                  {1'b1, 1'b0, 1'b0, 1'b0, {TRIG_W{1'b0}}, {OW{1'b0}}});
            exp_q.delete();
            stalled = 1'b0;
        end else begin
            if (stalled) check("stall_hold", {OutValid, OutData}, {1'b1, held});
            if (OutValid && OutReady) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL out_word: got 0x%0h expected nothing at %0t", OutData, $time);
                end else begin
                    check("out_word", OutData, exp_q.pop_front());
                end
            end
            stalled = OutValid && !OutReady;
            held    = OutData;
            if (ReqValid && ReqReady) begin
                check("accept_tok_low", TokToRegions, 1'b0);
                cur_id   = ReqTrigId;
                ev_reads = 0;
                since_rd = 1000;
            end
            since_rd++;
            if (Read) begin
                check("read_ctx", {TokFromRegions, TokToRegions, TrigIdReq}, {1'b0, 1'b1, cur_id});
                check("read_gap", (since_rd >= TOK_SETTLE + 2) ? TOK_SETTLE + 2 : since_rd, TOK_SETTLE + 2);
                ev_reads++;
                since_rd = 0;
            end
            if (probe_req != probe_done) begin
                if (probe_kind == 0) check("stall_reads", ev_reads, probe_exp);
                else check("idle_outs", {ReqReady, TokToRegions, OutValid, Read}, 4'b1000);
                probe_done = probe_req;
            end
        end
        if (to_req != to_done) begin
            total++;
            bad++;
            $display("FAIL timeout: got %0d expired waits expected 0", to_req - to_done);
            to_done = to_req;
        end
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge Clk);
        #1;
    endtask

    // Expected words follow from the hit list alone: min(n, MAX) data words, trunc when n > MAX.
    task automatic issue(input logic [TRIG_W-1:0] id, input bit keep_valid);
        int n, k, cyc;
        logic tr;
        n  = next_hits.size();
        k  = (n < MAX_HITS) ? n : MAX_HITS;
        tr = (n > MAX_HITS);
        exp_q.push_back({2'b01, DATA_W'(id)});
        for (int i = 0; i < k; i++) exp_q.push_back({2'b10, next_hits[i]});
        exp_q.push_back({2'b11, tr, 7'b0, 8'(k)});
        ReqTrigId = id;
        ReqValid  = 1'b1;
        cyc = 0;
        do begin
            @(negedge Clk);
            cyc++;
        end while (!ReqReady && cyc < 500);
        if (!ReqReady) to_req++;
        @(posedge Clk);
        #2;
        if (!keep_valid) ReqValid = 1'b0;
    endtask

    task automatic drain();
        int cyc;
        cyc = 0;
        while ((exp_q.size() != 0 || !ReqReady) && cyc < 3000) begin
            @(posedge Clk);
            #1;
            cyc++;
        end
        if (cyc >= 3000) to_req++;
        wait_cycles(1);
        probe_kind = 1;
        probe_req++;
        wait_cycles(1);
    endtask

    initial begin
        int cyc;
        #1 Reset = 1'b0;
        wait_cycles(3);
        Reset = 1'b1;
        wait_cycles(2);

        // Zero-hit event
        ready_mode = 2;
        next_hits.delete();
        issue(5'h0B, 1'b0);
        drain();

        // Three hits
        next_hits = '{16'h1234, 16'h00F0, 16'hFFFF};
        issue(5'h03, 1'b0);
        drain();

        // Truncation: more hits than MAX_HITS
        next_hits.delete();
        for (int i = 0; i < 8; i++) next_hits.push_back(DATA_W'(16'h0100 + i));
        issue(5'h07, 1'b0);
        drain();

        // Exactly MAX_HITS hits under backpressure: token wins, no truncation
        ready_mode = 1;
        next_hits.delete();
        for (int i = 0; i < 5; i++) next_hits.push_back(DATA_W'($urandom));
        issue(5'h11, 1'b0);
        wait_cycles(60);
        probe_kind = 0;
        probe_exp  = FIFO_DEPTH - 2;
        probe_req++;
        wait_cycles(2);
        ready_mode = 2;
        drain();

        // Reset in the second settle window
        next_hits = '{16'hAAAA, 16'h5555, 16'h0F0F, 16'hF0F0};
        issue(5'h15, 1'b0);
        cyc = 0;
        while (ev_reads < 1 && cyc < 200) begin
            @(posedge Clk);
            #1;
            cyc++;
        end
        if (ev_reads < 1) to_req++;
        @(posedge Clk);
        #1;
        Reset = 1'b0;
        wait_cycles(3);
        Reset = 1'b1;
        wait_cycles(2);
        next_hits = '{16'hBEEF, 16'h0001};
        issue(5'h16, 1'b0);
        drain();

        // Back-to-back requests with ReqValid held
        next_hits.delete();
        issue(5'h01, 1'b1);
        next_hits.delete();
        issue(5'h02, 1'b0);
        drain();

        // Random events, random downstream stalls
        repeat (25) begin
            ready_mode = ($urandom_range(0, 1) != 0) ? 0 : 2;
            next_hits.delete();
            for (int i = 0; i < int'($urandom_range(0, 8)); i++) next_hits.push_back(DATA_W'($urandom));
            issue(TRIG_W'($urandom), 1'b0);
            if ($urandom_range(0, 2) == 0) drain();
        end
        ready_mode = 0;
        drain();
        wait_cycles(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
